// File: rtl/alu_md.sv
// alu_md: parametrised EX-stage ALU with an iterative multiply/divide unit.
//
// Combinational ops (ADD/SUB/logic/compare/shift/LUI/MFHI/MFLO) resolve with
// zero latency on C/Zero. MULT/MULTU/DIV/DIVU are launched with start while
// idle and run for WIDTH+1 cycles. They update the architectural HI/LO
// registers and pulse done when finished.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset (aborts a running op)
//   A, B   - operands (A is the shift amount source for shifts)
//   ALUOp  - 5-bit operation select
//   start  - launches an iterative op; honoured only when idle
//   C      - combinational result
//   Zero   - C == 0
//   busy   - iterative unit running
//   done   - one-cycle pulse when HI/LO were written by an iterative op
//   hi, lo - HI/LO registers
module alu_md #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       ALUOp,
    input  logic             start,
    output logic [WIDTH-1:0] C,
    output logic             Zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_SLT  = 5'd5;
    localparam logic [4:0] OP_SLTU = 5'd6;
    localparam logic [4:0] OP_NOR  = 5'd7;
    localparam logic [4:0] OP_LUI  = 5'd8;
    localparam logic [4:0] OP_SLL  = 5'd9;
    localparam logic [4:0] OP_SRL  = 5'd10;
    localparam logic [4:0] OP_SLLV = 5'd11;
    localparam logic [4:0] OP_SRLV = 5'd12;
    localparam logic [4:0] OP_SRA  = 5'd13;
    localparam logic [4:0] OP_XOR  = 5'd14;
    localparam logic [4:0] OP_MULT = 5'd16;
    localparam logic [4:0] OP_MULTU= 5'd17;
    localparam logic [4:0] OP_DIV  = 5'd18;
    localparam logic [4:0] OP_DIVU = 5'd19;
    localparam logic [4:0] OP_MFHI = 5'd20;
    localparam logic [4:0] OP_MFLO = 5'd21;
    localparam logic [4:0] OP_MTHI = 5'd22;
    localparam logic [4:0] OP_MTLO = 5'd23;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Two's-complement negation helpers.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t               state_r, state_s;
    logic [SHW-1:0]       cnt_r;
    logic [2*WIDTH-1:0]   work_r;     // mult: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]     opnd_r;     // multiplicand or divisor magnitude
    logic                 is_div_r;
    logic                 neg_q_r;    // negate product / quotient
    logic                 neg_rem_r;  // remainder takes sign of A
    logic                 div0_r;
    logic                 busy_r, done_r;
    logic [WIDTH-1:0]     hi_r, lo_r;

    logic [WIDTH-1:0]     c_s;
    logic [SHW-1:0]       shamt_s;
    logic                 op_md_s, op_div_s, op_signed_s, launch_s;
    logic                 a_neg_s, b_neg_s;
    logic [WIDTH-1:0]     a_mag_s, b_mag_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_next_s;
    logic [WIDTH:0]       div_shift_s, div_diff_s;
    logic [2*WIDTH-1:0]   div_next_s;
    logic [2*WIDTH-1:0]   prod_fix_s;
    logic [WIDTH-1:0]     quot_fix_s, rem_fix_s;
    logic [WIDTH-1:0]     hi_fix_s, lo_fix_s;

    assign shamt_s     = A[SHW-1:0];
    assign op_md_s     = (ALUOp >= OP_MULT) && (ALUOp <= OP_DIVU);
    assign op_div_s    = (ALUOp == OP_DIV) || (ALUOp == OP_DIVU);
    assign op_signed_s = (ALUOp == OP_MULT) || (ALUOp == OP_DIV);
    assign launch_s    = (state_r == ST_IDLE) && start && op_md_s;
    assign a_neg_s     = op_signed_s && A[WIDTH-1];
    assign b_neg_s     = op_signed_s && B[WIDTH-1];
    assign a_mag_s     = a_neg_s ? neg_w(A) : A;
    assign b_mag_s     = b_neg_s ? neg_w(B) : B;

    // Zero-latency result mux.
    always_comb begin
        c_s = A;
        case (ALUOp)
            OP_NOP:           c_s = A;
            OP_ADD:           c_s = A + B;
            OP_SUB:           c_s = A - B;
            OP_AND:           c_s = A & B;
            OP_OR:            c_s = A | B;
            OP_SLT:           c_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU:          c_s = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_NOR:           c_s = ~(A | B);
            OP_LUI:           c_s = B << (WIDTH / 2);
            OP_SLL, OP_SLLV:  c_s = B << shamt_s;
            OP_SRL, OP_SRLV:  c_s = B >> shamt_s;
            OP_SRA:           c_s = $signed(B) >>> shamt_s;
            OP_XOR:           c_s = A ^ B;
            OP_MFHI:          c_s = hi_r;
            OP_MFLO:          c_s = lo_r;
            default:          c_s = A;
        endcase
    end

    assign C    = c_s;
    assign Zero = (c_s == {WIDTH{1'b0}});

    // One iteration of shift-add multiply and restoring divide.
    always_comb begin
        if (work_r[0]) begin
            mul_sum_s = {1'b0, work_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
        end else begin
            mul_sum_s = {1'b0, work_r[2*WIDTH-1:WIDTH]};
        end
        mul_next_s  = {mul_sum_s, work_r[WIDTH-1:1]};
        // Partial remainder shifted left with the next dividend bit; bit WIDTH of
        // the difference is the borrow that says "divisor did not fit".
        div_shift_s = {work_r[2*WIDTH-1:WIDTH], work_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        if (div_diff_s[WIDTH]) begin
            div_next_s = {div_shift_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b0};
        end else begin
            div_next_s = {div_diff_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b1};
        end
    end

    // Sign correction and final HI/LO values.
    always_comb begin
        prod_fix_s = neg_q_r   ? neg_2w(work_r) : work_r;
        quot_fix_s = neg_q_r   ? neg_w(work_r[WIDTH-1:0]) : work_r[WIDTH-1:0];
        rem_fix_s  = neg_rem_r ? neg_w(work_r[2*WIDTH-1:WIDTH]) : work_r[2*WIDTH-1:WIDTH];
        if (is_div_r) begin
            // With a zero divisor the remainder path already returns A.
            hi_fix_s = rem_fix_s;
            if (div0_r) begin
                lo_fix_s = {WIDTH{1'b1}};
            end else begin
                lo_fix_s = quot_fix_s;
            end
        end else begin
            hi_fix_s = prod_fix_s[2*WIDTH-1:WIDTH];
            lo_fix_s = prod_fix_s[WIDTH-1:0];
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) begin
                    state_s = ST_CALC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_FIX:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Iterative datapath, HI/LO and handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {SHW{1'b0}};
            work_r    <= {(2*WIDTH){1'b0}};
            opnd_r    <= {WIDTH{1'b0}};
            is_div_r  <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            div0_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (launch_s) begin
                        cnt_r     <= {SHW{1'b0}};
                        busy_r    <= 1'b1;
                        is_div_r  <= op_div_s;
                        neg_q_r   <= a_neg_s ^ b_neg_s;
                        neg_rem_r <= a_neg_s;
                        div0_r    <= (B == {WIDTH{1'b0}});
                        if (op_div_s) begin
                            work_r <= {{WIDTH{1'b0}}, a_mag_s};
                            opnd_r <= b_mag_s;
                        end else begin
                            work_r <= {{WIDTH{1'b0}}, b_mag_s};
                            opnd_r <= a_mag_s;
                        end
                    end
                    if (ALUOp == OP_MTHI) begin
                        hi_r <= A;
                    end
                    if (ALUOp == OP_MTLO) begin
                        lo_r <= A;
                    end
                end
                ST_CALC: begin
                    cnt_r  <= cnt_r + {{(SHW-1){1'b0}}, 1'b1};
                    work_r <= is_div_r ? div_next_s : mul_next_s;
                end
                ST_FIX: begin
                    hi_r   <= hi_fix_s;
                    lo_r   <= lo_fix_s;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: a 32-bit instance for the combinational ops
// and multiply/divide, plus an 8-bit instance for the narrow multiply case.
module tb_alu_md;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] a32, b32, c32, hi32, lo32;
    logic [4:0]  op32;
    logic        start32, zero32, busy32, done32;
    logic [7:0]  a8, b8, c8, hi8, lo8;
    logic [4:0]  op8;
    logic        start8, zero8, busy8, done8;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    alu_md #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .A(a32), .B(b32), .ALUOp(op32), .start(start32),
        .C(c32), .Zero(zero32), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
    );

    alu_md #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .ALUOp(op8), .start(start8),
        .C(c8), .Zero(zero8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference for the zero-latency ops (32-bit).
    function automatic logic [31:0] model_c(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] h,
                                            input logic [31:0] l);
        int unsigned sh;
        int sa, sb;
        sh = a % 32'd32;
        sa = a;
        sb = b;
        case (op)
            5'd0:         return a;
            5'd1:         return a + b;
            5'd2:         return a - b;
            5'd3:         return a & b;
            5'd4:         return a | b;
            5'd5:         return (sa < sb) ? 32'd1 : 32'd0;
            5'd6:         return (a < b) ? 32'd1 : 32'd0;
            5'd7:         return ~(a | b);
            5'd8:         return b * 32'd65536;
            5'd9, 5'd11:  return b << sh;
            5'd10, 5'd12: return b >> sh;
            5'd13:        return 32'(sb >>> sh);
            5'd14:        return a ^ b;
            5'd20:        return h;
            5'd21:        return l;
            default:      return a;
        endcase
    endfunction

    // Reference for MULT/MULTU/DIV/DIVU at width w (operands in the low w bits).
    task automatic model_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int w, output logic [31:0] h, output logic [31:0] l);
        longint sa, sb, ua, ub, q, r;
        logic [63:0] p, mask;
        mask = (64'd1 << w) - 64'd1;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = ua;
        sb = ub;
        if (a[w-1]) sa = ua - (longint'(1) << w);
        if (b[w-1]) sb = ub - (longint'(1) << w);
        h = 32'd0;
        l = 32'd0;
        case (op)
            5'd16, 5'd17: begin
                p = (op == 5'd16) ? 64'(sa * sb) : 64'(ua * ub);
                h = 32'((p >> w) & mask);
                l = 32'(p & mask);
            end
            5'd18, 5'd19: begin
                if (ub == 0) begin
                    l = 32'(mask);
                    h = a;
                end else begin
                    q = (op == 5'd18) ? sa / sb : ua / ub;
                    r = (op == 5'd18) ? sa % sb : ua % ub;
                    l = 32'(64'(q) & mask);
                    h = 32'(64'(r) & mask);
                end
            end
            default: ;
        endcase
    endtask

    // One 32-bit iterative op with full handshake timing checks.
    task automatic run_md32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        int busy_cnt, done_cnt;
        model_md(op, a, b, 32, eh, el);
        a32 = a; b32 = b; op32 = op; start32 = 1'b1;
        tick();
        start32 = 1'b0; op32 = 5'd0;
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) tick();
            a32 = $urandom; b32 = $urandom;
            if (busy32 === 1'b1) busy_cnt++;
            if (done32 === 1'b1) done_cnt++;
        end
        n_checks++;
        if (busy_cnt != 33) $display("FAIL md_busy_len op=%0d: got %0d required 33", op, busy_cnt);
        else n_pass++;
        n_checks++;
        if (done_cnt != 0) $display("FAIL md_early_done op=%0d: got %0d required 0", op, done_cnt);
        else n_pass++;
        tick();
        n_checks++;
        if (done32 !== 1'b1 || busy32 !== 1'b0)
            $display("FAIL md_done_edge op=%0d: done=%b busy=%b required done=1 busy=0", op, done32, busy32);
        else n_pass++;
        n_checks++;
        if (hi32 !== eh || lo32 !== el)
            $display("FAIL md_result op=%0d a=%h b=%h: hi=%h lo=%h required hi=%h lo=%h",
                     op, a, b, hi32, lo32, eh, el);
        else n_pass++;
        tick();
        n_checks++;
        if (done32 !== 1'b0) $display("FAIL md_done_pulse op=%0d: got %b required 0", op, done32);
        else n_pass++;
        exp_hi = eh;
        exp_lo = el;
    endtask

    // One 8-bit iterative op: done edge and HI/LO.
    task automatic run_md8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [31:0] eh, el;
        int e;
        model_md(op, {24'd0, a}, {24'd0, b}, 8, eh, el);
        a8 = a; b8 = b; op8 = op; start8 = 1'b1;
        tick();
        start8 = 1'b0; op8 = 5'd0;
        e = 0;
        while (done8 !== 1'b1 && e < 30) begin
            tick();
            e++;
        end
        n_checks++;
        if (e != 9) $display("FAIL md8_latency op=%0d: done at edge %0d required 9", op, e);
        else n_pass++;
        n_checks++;
        if (hi8 !== eh[7:0] || lo8 !== el[7:0])
            $display("FAIL md8_result op=%0d a=%h b=%h: hi=%h lo=%h required hi=%h lo=%h",
                     op, a, b, hi8, lo8, eh[7:0], el[7:0]);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a32 = 32'd0; b32 = 32'd0; op32 = 5'd0; start32 = 1'b0;
        a8 = 8'd0; b8 = 8'd0; op8 = 5'd0; start8 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy32 !== 1'b0 || done32 !== 1'b0 || hi32 !== 32'd0 || lo32 !== 32'd0)
            $display("FAIL reset32: busy=%b done=%b hi=%h lo=%h required all 0", busy32, done32, hi32, lo32);
        else n_pass++;
        n_checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || hi8 !== 8'd0 || lo8 !== 8'd0)
            $display("FAIL reset8: busy=%b done=%b hi=%h lo=%h required all 0", busy8, done8, hi8, lo8);
        else n_pass++;
    endtask

    task automatic test_comb_directed();
        a32 = 32'hFFFFFFFF; b32 = 32'd1; op32 = 5'd5; #1;
        n_checks++;
        if (c32 !== 32'd1) $display("FAIL slt_neg: got %h required 00000001", c32);
        else n_pass++;
        op32 = 5'd6; #1;
        n_checks++;
        if (c32 !== 32'd0 || zero32 !== 1'b1) $display("FAIL sltu_zero: C=%h Zero=%b required 0/1", c32, zero32);
        else n_pass++;
        a32 = 32'd4; b32 = 32'h80000000; op32 = 5'd13; #1;
        n_checks++;
        if (c32 !== 32'hF8000000) $display("FAIL sra: got %h required f8000000", c32);
        else n_pass++;
        op32 = 5'd0;
    endtask

    // Random ops, one per cycle; MTHI/MTLO take effect at the following edge.
    task automatic test_comb_random();
        logic [31:0] ec;
        for (int i = 0; i < 200; i++) begin
            op32 = 5'($urandom_range(0, 31));
            a32 = $urandom;
            b32 = ($urandom_range(0, 7) == 0) ? a32 : $urandom;
            #1;
            ec = model_c(op32, a32, b32, exp_hi, exp_lo);
            n_checks++;
            if (c32 !== ec || zero32 !== (ec == 32'd0))
                $display("FAIL comb op=%0d a=%h b=%h: C=%h Zero=%b required C=%h Zero=%b",
                         op32, a32, b32, c32, zero32, ec, (ec == 32'd0));
            else n_pass++;
            tick();
            if (op32 == 5'd22) exp_hi = a32;
            if (op32 == 5'd23) exp_lo = a32;
        end
        op32 = 5'd0;
    endtask

    task automatic test_md_directed();
        run_md32(5'd16, 32'hFFFFFFFD, 32'd5);
        op32 = 5'd21; #1;
        n_checks++;
        if (c32 !== 32'hFFFFFFF1 || hi32 !== 32'hFFFFFFFF)
            $display("FAIL mult_mflo: C=%h hi=%h required fffffff1/ffffffff", c32, hi32);
        else n_pass++;
        run_md32(5'd19, 32'd100, 32'd7);
        n_checks++;
        if (lo32 !== 32'd14 || hi32 !== 32'd2) $display("FAIL divu_100_7: lo=%h hi=%h required e/2", lo32, hi32);
        else n_pass++;
        run_md32(5'd18, 32'hFFFFFFF9, 32'd2);
        n_checks++;
        if (lo32 !== 32'hFFFFFFFD || hi32 !== 32'hFFFFFFFF)
            $display("FAIL div_m7_2: lo=%h hi=%h required fffffffd/ffffffff", lo32, hi32);
        else n_pass++;
        run_md32(5'd18, 32'h80000000, 32'hFFFFFFFF);
        n_checks++;
        if (lo32 !== 32'h80000000 || hi32 !== 32'd0)
            $display("FAIL div_min_m1: lo=%h hi=%h required 80000000/0", lo32, hi32);
        else n_pass++;
        run_md32(5'd19, 32'd9, 32'd0);
        n_checks++;
        if (lo32 !== 32'hFFFFFFFF || hi32 !== 32'd9) $display("FAIL divu_by0: lo=%h hi=%h required ffffffff/9", lo32, hi32);
        else n_pass++;
        run_md32(5'd18, 32'hFFFFFFF0, 32'd0);
    endtask

    task automatic test_md_random();
        logic [4:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            op = 5'(16 + $urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: a = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            run_md32(op, a, b);
        end
    endtask

    task automatic test_back_to_back();
        int e;
        a32 = 32'd6; b32 = 32'd7; op32 = 5'd17; start32 = 1'b1;
        tick();
        start32 = 1'b0; op32 = 5'd0;
        for (int k = 1; k <= 4; k++) tick();
        a32 = 32'd100; b32 = 32'd100; op32 = 5'd17; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        a32 = 32'h0000DEAD; op32 = 5'd23;
        tick();
        op32 = 5'd21; #1;
        n_checks++;
        if (c32 !== exp_lo) $display("FAIL mflo_busy: got %h required %h", c32, exp_lo);
        else n_pass++;
        op32 = 5'd0;
        e = 6;
        while (done32 !== 1'b1 && e < 60) begin
            tick();
            e++;
        end
        n_checks++;
        if (e != 33) $display("FAIL restart_latency: done at edge %0d required 33", e);
        else n_pass++;
        n_checks++;
        if (lo32 !== 32'd42 || hi32 !== 32'd0) $display("FAIL restart_ignored: lo=%h hi=%h required 2a/0", lo32, hi32);
        else n_pass++;
        exp_lo = 32'd42; exp_hi = 32'd0;
        a32 = 32'h55; op32 = 5'd23;
        tick();
        n_checks++;
        if (lo32 !== 32'h55) $display("FAIL mtlo_idle: got %h required 55", lo32);
        else n_pass++;
        exp_lo = 32'h55;
        a32 = 32'h66; op32 = 5'd22; start32 = 1'b1;
        tick();
        start32 = 1'b0; op32 = 5'd0;
        n_checks++;
        if (hi32 !== 32'h66 || busy32 !== 1'b0) $display("FAIL mthi_start: hi=%h busy=%b required 66/0", hi32, busy32);
        else n_pass++;
        exp_hi = 32'h66;
    endtask

    task automatic test_reset_abort();
        int dcnt;
        a32 = 32'd1000; b32 = 32'd3; op32 = 5'd18; start32 = 1'b1;
        tick();
        start32 = 1'b0; op32 = 5'd0;
        for (int k = 1; k <= 9; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy32 !== 1'b0 || hi32 !== 32'd0 || lo32 !== 32'd0)
            $display("FAIL reset_abort: busy=%b hi=%h lo=%h required 0/0/0", busy32, hi32, lo32);
        else n_pass++;
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done32 === 1'b1 || busy32 === 1'b1) dcnt++;
        end
        n_checks++;
        if (dcnt != 0) $display("FAIL reset_abort_quiet: got %0d active cycles required 0", dcnt);
        else n_pass++;
        exp_hi = 32'd0; exp_lo = 32'd0;
    endtask

    task automatic test_width8();
        run_md8(5'd17, 8'hFF, 8'hFF);
        n_checks++;
        if (hi8 !== 8'hFE || lo8 !== 8'h01) $display("FAIL multu8_ff: hi=%h lo=%h required fe/01", hi8, lo8);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            run_md8(5'(16 + $urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom));
        end
        run_md8(5'd18, 8'h80, 8'hFF);
    endtask

    initial begin
        test_reset();
        test_comb_directed();
        test_md_directed();
        test_comb_random();
        test_md_random();
        test_back_to_back();
        test_reset_abort();
        test_width8();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
